// File: rtl/spfs_arbiter.sv
// spfs_arbiter: two-requester SPI mode-0 frame arbiter; req/rsp ports per requester, spfs_* serial link, busy_o/owner_o status
module spfs_arbiter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req0_valid_i,
  output logic       req0_ready_o,
  input  logic [7:0] req0_data_i,
  input  logic       req0_last_i,
  output logic       rsp0_valid_o,
  output logic [7:0] rsp0_data_o,
  input  logic       req1_valid_i,
  output logic       req1_ready_o,
  input  logic [7:0] req1_data_i,
  input  logic       req1_last_i,
  output logic       rsp1_valid_o,
  output logic [7:0] rsp1_data_o,
  output logic       spfs_clk_o,
  output logic       spfs_cs_o,
  output logic       spfs_mosi_o,
  input  logic       spfs_miso_i,
  output logic       busy_o,
  output logic       owner_o
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, WAIT, HOLD, GAP} state_t;
  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);
  state_t state, state_n;
  logic [7:0] cnt, tx, rx, data;
  logic [3:0] bits;
  logic last, rr_last, g0, g1, acc, sel, tick;
  assign tick = cnt == 8'd0;
  assign g0 = req0_valid_i & (~req1_valid_i | rr_last);
  assign g1 = req1_valid_i & (~req0_valid_i | ~rr_last);
  assign acc = (req0_ready_o & req0_valid_i) | (req1_ready_o & req1_valid_i);
  assign sel = state == IDLE ? g1 : owner_o;
  assign data = sel ? req1_data_i : req0_data_i;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? SETUP : IDLE;
      SETUP:   state_n = tick ? SHIFT : SETUP;
      SHIFT:   state_n = tick && bits == 4'd15 ? DONE : SHIFT;
      DONE:    state_n = last ? HOLD : WAIT;
      WAIT:    state_n = acc ? SETUP : WAIT;
      HOLD:    state_n = tick ? GAP : HOLD;
      GAP:     state_n = tick ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    req0_ready_o = state == IDLE ? g0 : state == WAIT && !owner_o;
    req1_ready_o = state == IDLE ? g1 : state == WAIT && owner_o;
    rsp0_valid_o = state == DONE && !owner_o;
    rsp1_valid_o = state == DONE && owner_o;
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cnt <= RELOAD;
      tx <= 8'd0;
      rx <= 8'd0;
      bits <= 4'd0;
      last <= 1'b0;
      rr_last <= 1'b1;
      owner_o <= 1'b0;
      spfs_clk_o <= 1'b0;
      spfs_cs_o <= 1'b1;
      spfs_mosi_o <= 1'b0;
      rsp0_data_o <= 8'd0;
      rsp1_data_o <= 8'd0;
    end else begin
      cnt <= tick || state_n != state ? RELOAD : cnt - 8'd1;
      if (acc) begin
        tx <= {data[6:0], 1'b0};
        spfs_mosi_o <= data[7];
        last <= sel ? req1_last_i : req0_last_i;
        owner_o <= sel;
        spfs_cs_o <= 1'b0;
      end
      if (acc && state == IDLE) rr_last <= g1;
      if (state == SETUP && tick) begin
        spfs_clk_o <= 1'b1;
        bits <= 4'd0;
      end
      // the last half-period is already low, so SCLK is left there for DONE
      if (state == SHIFT && tick) begin
        bits <= bits + 4'd1;
        if (bits != 4'd15) spfs_clk_o <= ~spfs_clk_o;
        if (spfs_clk_o) begin
          spfs_mosi_o <= tx[7];
          tx <= {tx[6:0], 1'b0};
        end
      end
      // first cycle of a high half-period is the rising-edge cycle
      if (state == SHIFT && spfs_clk_o && cnt == RELOAD) rx <= {rx[6:0], spfs_miso_i};
      if (state == SHIFT && tick && bits == 4'd15 && !owner_o) rsp0_data_o <= rx;
      if (state == SHIFT && tick && bits == 4'd15 && owner_o) rsp1_data_o <= rx;
      if (state == HOLD && tick) spfs_cs_o <= 1'b1;
    end
endmodule

// File: tb/tb_spfs_arbiter.sv
// tb_spfs_arbiter: scoreboard bench for spfs_arbiter with an SPI slave model
module tb_spfs_arbiter;
  logic clk = 0, rst_n = 0;
  logic v0 = 0, l0 = 0, v1 = 0, l1 = 0;
  logic [7:0] d0 = 0, d1 = 0;
  logic r0, r1, rv0, rv1, sclk, cs, mosi, miso, busy, owner;
  logic [7:0] rd0, rd1;
  logic u_v = 0, u_l = 0;
  logic [7:0] u_d = 0;
  logic u_r0, u_r1, u_rv0, u_rv1, u_sclk, u_cs, u_mosi, u_busy, u_owner;
  logic [7:0] u_rd0, u_rd1;
  always #5 clk = ~clk;
  spfs_arbiter #(.CLK_DIV(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_data_i(d0), .req0_last_i(l0),
    .rsp0_valid_o(rv0), .rsp0_data_o(rd0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_data_i(d1), .req1_last_i(l1),
    .rsp1_valid_o(rv1), .rsp1_data_o(rd1),
    .spfs_clk_o(sclk), .spfs_cs_o(cs), .spfs_mosi_o(mosi), .spfs_miso_i(miso),
    .busy_o(busy), .owner_o(owner)
  );
  spfs_arbiter #(.CLK_DIV(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(u_v), .req0_ready_o(u_r0), .req0_data_i(u_d), .req0_last_i(u_l),
    .rsp0_valid_o(u_rv0), .rsp0_data_o(u_rd0),
    .req1_valid_i(1'b0), .req1_ready_o(u_r1), .req1_data_i(8'h00), .req1_last_i(1'b0),
    .rsp1_valid_o(u_rv1), .rsp1_data_o(u_rd1),
    .spfs_clk_o(u_sclk), .spfs_cs_o(u_cs), .spfs_mosi_o(u_mosi), .spfs_miso_i(u_mosi),
    .busy_o(u_busy), .owner_o(u_owner)
  );
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] f(input int n);
    logic [7:0] m = 8'(n * 91);
    return 8'h3C ^ m;
  endfunction
  int k = 0, b = 0, rises = 0;
  logic [7:0] msr = 0, cur;
  assign cur = f(k);
  assign miso = cur[3'(7 - b)];
  always @(negedge sclk or posedge cs)
    if (cs) b <= 0;
    else if (b == 7) begin
      b <= 0;
      k <= k + 1;
    end else b <= b + 1;
  always @(posedge sclk) begin
    msr <= {msr[6:0], mosi};
    rises <= rises + 1;
  end
  typedef struct {logic p; logic [7:0] rx; logic [7:0] tx; int t;} ent_t;
  ent_t sb[$];
  int cyc = 0, rsp_cnt = 0, snap = 0, bad_rdy = 0, both = 0, cs_hi = 0;
  logic watch_cs = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst_n) snap <= rises;
    else if (rv0 || rv1) begin
      rsp_cnt <= rsp_cnt + 1;
      chk("rsp_both", 32'(rv0 && rv1), 0);
      if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        chk("rsp_owner", 32'(rv1), 32'(sb[0].p));
        chk("rsp_data", rv1 ? rd1 : rd0, sb[0].rx);
        chk("mosi_byte", msr, sb[0].tx);
        chk("latency", cyc - sb[0].t, 35);
        void'(sb.pop_front());
      end
      chk("sclk_rises", rises - snap, 8);
      snap <= rises;
    end
    if (busy && ((r0 && owner) || (r1 && !owner))) bad_rdy <= bad_rdy + 1;
    if (r0 && r1) both <= both + 1;
    if (watch_cs && cs) cs_hi <= cs_hi + 1;
  end
  task automatic drive(input logic p, input logic [7:0] d, input logic l);
    if (p) begin v1 = 1; d1 = d; l1 = l; end
    else begin v0 = 1; d0 = d; l0 = l; end
  endtask
  task automatic await_acc(input logic p, output int n);
    n = 0;
    #1;
    while (!(p ? r1 : r0) && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 500) chk("accept_timeout", 32'(p ? r1 : r0), 1);
    else sb.push_back('{p, f(k), p ? d1 : d0, cyc});
    @(posedge clk); #1;
    if (p) v1 = 0; else v0 = 0;
  endtask
  task automatic send(input logic p, input logic [7:0] d, input logic l);
    int n;
    drive(p, d, l);
    await_acc(p, n);
  endtask
  task automatic wait_idle();
    int i = 0;
    while (busy && i < 2000) begin
      @(negedge clk); i++;
    end
    if (i >= 2000) chk("idle_timeout", 32'(busy), 0);
    @(negedge clk);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, csh, stall, rc;
    logic p;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_ready", {r0, r1}, 0);
    chk("rst_rsp", {rv0, rv1, rd0, rd1}, 0);
    rst_n = 1;
    @(negedge clk);
    send(0, 8'hA5, 1);
    csh = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i <= 37 && cs) csh++;
      if (i <= 2) chk("sclk_setup", 32'(sclk), 0);
      if (i == 38) chk("cs_rise", 32'(cs), 1);
      if (i == 39) chk("busy_gap", 32'(busy), 1);
      if (i == 40) chk("busy_drop", 32'(busy), 0);
    end
    chk("cs_low_frame", csh, 0);
    chk("rsp0_hold", rd0, 8'h3C);
    send(0, 8'h01, 0);
    watch_cs = 1;
    drive(1, 8'h77, 1);
    send(0, 8'h02, 0);
    send(0, 8'h03, 1);
    watch_cs = 0;
    await_acc(1, n);
    chk("atomic_grant_delay", n, 40);
    chk("owner_req1", 32'(owner), 1);
    wait_idle();
    chk("cs_between_bytes", cs_hi, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    drive(0, 8'h10, 1);
    drive(1, 8'h20, 1);
    for (int g = 0; g < 4; g++) begin
      n = 0;
      #1;
      while (!(r0 || r1) && n < 500) begin
        @(negedge clk); #1; n++;
      end
      p = r1;
      chk("rr_grant", 32'(p), 32'(g % 2));
      sb.push_back('{p, f(k), p ? d1 : d0, cyc});
      @(posedge clk); #1;
      chk("rr_owner", 32'(owner), 32'(p));
      if (g == 3) begin v0 = 0; v1 = 0; end
      else if (p) d1 = d1 + 8'd1;
      else d0 = d0 + 8'd1;
    end
    wait_idle();
    send(1, 8'hFF, 0);
    drive(0, 8'h11, 1);
    repeat (35) @(negedge clk);
    stall = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cs || sclk || r0 || !r1) stall++;
    end
    chk("wait_stall", stall, 0);
    send(1, 8'h22, 1);
    await_acc(0, n);
    wait_idle();
    send(0, 8'h96, 1);
    repeat (19) @(negedge clk);
    chk("pre_reset_sclk", 32'(sclk), 1);
    rc = rsp_cnt;
    rst_n = 0;
    #1;
    chk("reset_cs", 32'(cs), 1);
    chk("reset_sclk", 32'(sclk), 0);
    chk("reset_busy", 32'(busy), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    chk("no_rsp_after_reset", rsp_cnt, rc);
    send(0, 8'hC3, 1);
    wait_idle();
    u_v = 1; u_d = 8'h5A; u_l = 1;
    n = 0;
    #1;
    while (!u_r0 && n < 500) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1;
    u_v = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (u_rv0) break;
    end
    chk("div1_latency", n, 18);
    chk("div1_data", u_rd0, 8'h5A);
    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("nonowner_ready", bad_rdy, 0);
    chk("both_ready", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
